// File: rtl/teknofest_pkg.sv
// Shared constants for the TEKNOFEST RAM loader and the RAM dump engine.
//   PROGRAM_SEQUENCE / PROG_SEQ_LENGTH : ASCII sync word that opens every frame
//   CPU_CLK / BAUD_RATE                : default core clock and serial bit rate
//   dump_state_t                       : state encoding of the dump FSM
//   prog_seq_byte / word_byte          : byte pickers for the frame builder
package teknofest_pkg;

  localparam int CPU_CLK         = 60_000_000;
  localparam int BAUD_RATE       = 9600;
  localparam int PROG_SEQ_LENGTH = 9;
  localparam logic [71:0] PROGRAM_SEQUENCE = "TEKNOFEST";

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_HEADER,
    DUMP_LENGTH,
    DUMP_READ,
    DUMP_CAPTURE,
    DUMP_DATA,
    DUMP_DONE
  } dump_state_t;

  // Byte idx of the sync word, 'T' (leftmost character) at idx 0.
  function automatic logic [7:0] prog_seq_byte(input logic [3:0] idx);
    logic [71:0] seq;
    seq = PROGRAM_SEQUENCE << (8 * idx);
    return seq[71:64];
  endfunction

  // Byte idx of a 32-bit word, most significant byte at idx 0.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [31:0] s;
    s = w << (8 * idx);
    return s[31:24];
  endfunction

endpackage

// File: rtl/teknofest_uart_tx.sv
// 8N1 byte serializer, LSB first, idle-high line.
//   clk, rst  : clock, synchronous active-high reset
//   tx_valid  : byte offered by the producer
//   tx_ready  : serializer can take a byte this cycle (valid && ready transfers)
//   tx_byte   : byte to send, held stable by the producer until the transfer
//   tx_o      : registered serial line
// Each bit lasts DIV cycles. Ready is also raised in the last cycle of the stop
// bit so a following byte starts without any idle cycle in between.
module teknofest_uart_tx #(
  parameter int DIV = 6250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_byte,
  output logic       tx_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [9:0]       shreg;
  logic             active;
  logic             bit_end;

  assign bit_end  = (cnt == CNT_W'(DIV - 1));
  assign tx_ready = !active || (bit_end && (bit_idx == 4'd9));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      active  <= 1'b0;
      tx_o    <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      // Frame is {stop, data[7:0], start}; the start bit goes out immediately.
      shreg   <= {1'b1, tx_byte, 1'b0};
      cnt     <= '0;
      bit_idx <= '0;
      active  <= 1'b1;
      tx_o    <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active  <= 1'b0;
          bit_idx <= '0;
          tx_o    <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
          tx_o    <= shreg[1];
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/teknofest_ram_dump.sv
// UART readback engine for the TEKNOFEST program RAM. On a start request it
// sends "TEKNOFEST", the 32-bit word count (MSB first) and then count words
// read from base, base+1, ... (each MSB first), in the same framing the RAM's
// UART loader accepts.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   dump_start_i       : start request, only looked at while idle
//   dump_base_i        : first word address, latched on start
//   dump_count_i       : number of words, latched on start
//   rd_en_o, rd_addr_o : RAM read port request (data returns next cycle)
//   rd_data_i          : RAM read data
//   ram_dump_tx_o      : serial output, 8N1
//   busy_o, done_o     : activity flag and end-of-dump pulse
module teknofest_ram_dump #(
  parameter int CLK_FREQ   = teknofest_pkg::CPU_CLK,
  parameter int BAUD_RATE  = teknofest_pkg::BAUD_RATE,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dump_start_i,
  input  logic [ADDR_WIDTH-1:0] dump_base_i,
  input  logic [31:0]           dump_count_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [31:0]           rd_data_i,
  output logic                  ram_dump_tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  import teknofest_pkg::*;

  localparam int DIV = CLK_FREQ / BAUD_RATE;

  dump_state_t           state, state_next;
  logic [3:0]            hdr_idx;
  logic [1:0]            byte_idx;
  logic [31:0]           words_left;
  logic [31:0]           count_q;
  logic [31:0]           word_q;
  logic [ADDR_WIDTH-1:0] addr;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_fire;

  assign tx_fire = tx_valid && tx_ready;

  // READ and DONE both wait for the serializer to finish the previous byte:
  // the read lands on the last stop-bit cycle, so every word is preceded by a
  // READ + CAPTURE gap of exactly two idle line cycles, and done_o marks the
  // end of the final stop bit.
  assign rd_en_o   = (state == DUMP_READ) && tx_ready;
  assign done_o    = (state == DUMP_DONE) && tx_ready;
  assign busy_o    = (state != DUMP_IDLE);
  assign rd_addr_o = addr;

  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_byte    = '0;
    case (state)
      DUMP_IDLE: begin
        if (dump_start_i) state_next = DUMP_HEADER;
      end
      DUMP_HEADER: begin
        tx_valid = 1'b1;
        tx_byte  = prog_seq_byte(hdr_idx);
        if (tx_fire && (hdr_idx == 4'(PROG_SEQ_LENGTH - 1))) state_next = DUMP_LENGTH;
      end
      DUMP_LENGTH: begin
        tx_valid = 1'b1;
        tx_byte  = word_byte(count_q, byte_idx);
        if (tx_fire && (byte_idx == 2'd3))
          state_next = (count_q == 32'd0) ? DUMP_DONE : DUMP_READ;
      end
      DUMP_READ: begin
        if (tx_ready) state_next = DUMP_CAPTURE;
      end
      DUMP_CAPTURE: begin
        state_next = DUMP_DATA;
      end
      DUMP_DATA: begin
        tx_valid = 1'b1;
        tx_byte  = word_byte(word_q, byte_idx);
        if (tx_fire && (byte_idx == 2'd3))
          state_next = (words_left != 32'd0) ? DUMP_READ : DUMP_DONE;
      end
      DUMP_DONE: begin
        if (tx_ready) state_next = DUMP_IDLE;
      end
      default: state_next = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= DUMP_IDLE;
      hdr_idx    <= '0;
      byte_idx   <= '0;
      words_left <= '0;
      count_q    <= '0;
      addr       <= '0;
    end else begin
      state <= state_next;
      case (state)
        DUMP_IDLE: begin
          if (dump_start_i) begin
            addr       <= dump_base_i;
            count_q    <= dump_count_i;
            words_left <= dump_count_i;
            hdr_idx    <= '0;
            byte_idx   <= '0;
          end
        end
        DUMP_HEADER: begin
          if (tx_fire)
            hdr_idx <= (hdr_idx == 4'(PROG_SEQ_LENGTH - 1)) ? 4'd0 : hdr_idx + 4'd1;
        end
        DUMP_LENGTH, DUMP_DATA: begin
          if (tx_fire) byte_idx <= byte_idx + 2'd1;
        end
        DUMP_CAPTURE: begin
          words_left <= words_left - 32'd1;
          addr       <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Captured read word; pure data, no reset needed.
  always_ff @(posedge clk_i) begin
    if (state == DUMP_CAPTURE) word_q <= rd_data_i;
  end

  teknofest_uart_tx #(
    .DIV (DIV)
  ) u_tx (
    .clk      (clk_i),
    .rst      (rst_i),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_byte  (tx_byte),
    .tx_o     (ram_dump_tx_o)
  );

endmodule
